// File: rtl/mux_unstriping_pkg.sv
// Shared defaults and FSM encoding for the two-lane unstriper.
package mux_unstriping_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    // Lane the output stage is waiting on next.
    typedef enum logic {
        SERVE0 = 1'b0,
        SERVE1 = 1'b1
    } serve_state_t;

endpackage : mux_unstriping_pkg

// File: rtl/mux_unstriping_lane_fifo.sv
// Per-lane elastic FIFO absorbing inter-lane skew. Read data is the
// registered head entry, so a pop never sees a word pushed in the same cycle.
module lane_fifo
    import mux_unstriping_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    output logic              overflow
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign dout  = mem[rd_ptr];

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;

    // Storage array: written on accepted pushes only.
    // NOTE: the data array carries no reset; the pointers and count alone
    // decide which entries are live, so stale contents are never observed.
    always_ff @(posedge clk_2f) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap modulo FIFO_DEPTH by width.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : lane_fifo

// File: rtl/mux_unstriping.sv
// Two-lane receive unstriper: buffers each lane and re-interleaves the words
// strictly lane 0, lane 1, lane 0, ... into one registered output stream.
module mux_unstriping
    import mux_unstriping_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              valid_in1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              sel,
    output logic              overflow_err,
    output logic [PTR_W:0]    fill0,
    output logic [PTR_W:0]    fill1
);

    serve_state_t      state_q;
    serve_state_t      state_d;
    logic              pop0;
    logic              pop1;
    logic [DATA_W-1:0] dout0;
    logic [DATA_W-1:0] dout1;
    logic              empty0;
    logic              empty1;
    logic              full0;
    logic              full1;
    logic              ovf0;
    logic              ovf1;

    lane_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_fifo0 (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .push     (valid_in0),
        .din      (lane_0),
        .pop      (pop0),
        .dout     (dout0),
        .full     (full0),
        .empty    (empty0),
        .count    (fill0),
        .overflow (ovf0)
    );

    lane_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) u_fifo1 (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .push     (valid_in1),
        .din      (lane_1),
        .pop      (pop1),
        .dout     (dout1),
        .full     (full1),
        .empty    (empty1),
        .count    (fill1),
        .overflow (ovf1)
    );

    // Full flags are not needed here: overflow is reported by the FIFOs.
    logic unused_full;
    assign unused_full = full0 | full1;

    assign sel = state_q;

    // Serving-lane state register.
    always_ff @(posedge clk_2f) begin
        if (!reset) state_q <= SERVE0;
        else        state_q <= state_d;
    end

    // Pop the lane being served only if it holds a word; never skip a lane.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        pop0    = 1'b0;
        pop1    = 1'b0;
        case (state_q)
            SERVE0: if (!empty0) begin
                pop0    = 1'b1;
                state_d = SERVE1;
            end
            SERVE1: if (!empty1) begin
                pop1    = 1'b1;
                state_d = SERVE0;
            end
            default: state_d = SERVE0;
        endcase
    end

    // Output register: capture the popped head, otherwise hold the last word.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop0 | pop1;
            if (pop0)      data_out <= dout0;
            else if (pop1) data_out <= dout1;
        end
    end

    // Sticky flag: any dropped write on either lane until reset.
    always_ff @(posedge clk_2f) begin
        if (!reset)           overflow_err <= 1'b0;
        else if (ovf0 | ovf1) overflow_err <= 1'b1;
    end

endmodule : mux_unstriping
